// File: rtl/fwd_pkg.sv
// fwd_pkg: operand-forwarding select encodings and register-index width
package fwd_pkg;
    localparam int REG_W = 5;
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EXM0 = 2'b01;
    localparam logic [1:0] FWD_EXM1 = 2'b10;
    localparam logic [1:0] FWD_MWB  = 2'b11;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: one ID source operand against the EX and MEM producers of both slots
module fwd_match
    import fwd_pkg::*;
#(
    parameter int W = REG_W
) (
    input  logic         valid,
    input  logic [W-1:0] src,
    input  logic [1:0]   ex_wr_en,
    input  logic [1:0]   ex_is_load,
    input  logic [W-1:0] ex_rd0,
    input  logic [W-1:0] ex_rd1,
    input  logic [1:0]   mem_wr_en,
    input  logic [W-1:0] mem_rd0,
    input  logic [W-1:0] mem_rd1,
    output logic [1:0]   sel,
    output logic         mwb_slot,
    output logic         load_hit
);
    logic live, e0, e1, m0, m1;

    assign live = valid && (src != '0);
    assign e0 = live && ex_wr_en[0] && (ex_rd0 == src);
    assign e1 = live && ex_wr_en[1] && (ex_rd1 == src);
    assign m0 = live && mem_wr_en[0] && (mem_rd0 == src);
    assign m1 = live && mem_wr_en[1] && (mem_rd1 == src);

    // youngest producer wins: EX slot1, EX slot0, MEM slot1, MEM slot0
    assign sel = e1 ? FWD_EXM1 : e0 ? FWD_EXM0 : (m1 || m0) ? FWD_MWB : FWD_RF;
    assign mwb_slot = !e1 && !e0 && m1;
    assign load_hit = (e1 && ex_is_load[1]) || (e0 && ex_is_load[0]);
endmodule

// File: rtl/ex_fwd_ctrl.sv
// ex_fwd_ctrl: registered forwarding selects for the dual-issue EX stage with load-use stall
module ex_fwd_ctrl #(
    parameter int REG_W = fwd_pkg::REG_W,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         id_valid,
    input  logic [REG_W-1:0]   id_rs0,
    input  logic [REG_W-1:0]   id_rt0,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rt1,
    input  logic [1:0]         ex_wr_en,
    input  logic [1:0]         ex_is_load,
    input  logic [REG_W-1:0]   ex_rd0,
    input  logic [REG_W-1:0]   ex_rd1,
    input  logic [1:0]         mem_wr_en,
    input  logic [REG_W-1:0]   mem_rd0,
    input  logic [REG_W-1:0]   mem_rd1,
    input  logic               ext_stall,
    input  logic               flush,
    output logic [4*SEL_W-1:0] fwd_sel,
    output logic [3:0]         mwb_slot,
    output logic               load_use_stall,
    output logic [CNT_W-1:0]   lu_count
);
    logic [REG_W-1:0]   src [4];
    logic [4*SEL_W-1:0] nxt_sel;
    logic [3:0]         nxt_mwb;
    logic [3:0]         hit;

    assign src[0] = id_rs0;
    assign src[1] = id_rt0;
    assign src[2] = id_rs1;
    assign src[3] = id_rt1;

    for (genvar i = 0; i < 4; i++) begin : g_op
        fwd_match #(.W(REG_W)) u_match (
            .valid      (id_valid[i/2]),
            .src        (src[i]),
            .ex_wr_en   (ex_wr_en),
            .ex_is_load (ex_is_load),
            .ex_rd0     (ex_rd0),
            .ex_rd1     (ex_rd1),
            .mem_wr_en  (mem_wr_en),
            .mem_rd0    (mem_rd0),
            .mem_rd1    (mem_rd1),
            .sel        (nxt_sel[i*SEL_W +: SEL_W]),
            .mwb_slot   (nxt_mwb[i]),
            .load_hit   (hit[i])
        );
    end

    assign load_use_stall = |hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_sel  <= '0;
            mwb_slot <= '0;
            lu_count <= '0;
        end else begin
            if (flush) begin
                fwd_sel  <= '0;
                mwb_slot <= '0;
            end else if (!ext_stall) begin
                // a load-use stall injects a bubble; the next cycle sees the load in MEM
                fwd_sel  <= load_use_stall ? '0 : nxt_sel;
                mwb_slot <= load_use_stall ? '0 : nxt_mwb;
            end
            if (load_use_stall && !ext_stall && !flush && lu_count != '1)
                lu_count <= lu_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// tb_ex_fwd_ctrl: directed checks of forwarding priority, load-use stall, hold/flush and counter saturation
module tb_ex_fwd_ctrl;
    logic       clk = 0;
    logic       rst;
    logic [1:0] id_valid;
    logic [4:0] id_rs0, id_rt0, id_rs1, id_rt1;
    logic [1:0] ex_wr_en, ex_is_load;
    logic [4:0] ex_rd0, ex_rd1;
    logic [1:0] mem_wr_en;
    logic [4:0] mem_rd0, mem_rd1;
    logic       ext_stall, flush;
    logic [7:0] fwd_sel;
    logic [3:0] mwb_slot;
    logic       load_use_stall;
    logic [15:0] lu_count;
    int passed = 0;
    int total  = 0;

    ex_fwd_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs0(id_rs0), .id_rt0(id_rt0), .id_rs1(id_rs1), .id_rt1(id_rt1),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd0(ex_rd0), .ex_rd1(ex_rd1),
        .mem_wr_en(mem_wr_en), .mem_rd0(mem_rd0), .mem_rd1(mem_rd1),
        .ext_stall(ext_stall), .flush(flush), .fwd_sel(fwd_sel), .mwb_slot(mwb_slot),
        .load_use_stall(load_use_stall), .lu_count(lu_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        id_valid = 2'b00; id_rs0 = 0; id_rt0 = 0; id_rs1 = 0; id_rt1 = 0;
        ex_wr_en = 0; ex_is_load = 0; ex_rd0 = 0; ex_rd1 = 0;
        mem_wr_en = 0; mem_rd0 = 0; mem_rd1 = 0;
        ext_stall = 0; flush = 0;
    endtask

    task automatic test_reset();
        clear();
        rst = 1;
        id_valid = 2'b01; id_rs0 = 9; ex_wr_en = 2'b01; ex_is_load = 2'b01; ex_rd0 = 9;
        #1;
        total++;
        if (load_use_stall !== 1'b1) $display("FAIL rst_stall_comb: got %b want 1", load_use_stall); else passed++;
        step(); step();
        rst = 0;
        clear();
        #1;
        total++;
        if (fwd_sel !== 8'h00) $display("FAIL rst_fwd_sel: got %h want 00", fwd_sel); else passed++;
        total++;
        if (mwb_slot !== 4'h0) $display("FAIL rst_mwb_slot: got %h want 0", mwb_slot); else passed++;
        total++;
        if (lu_count !== 16'h0) $display("FAIL rst_lu_count: got %h want 0000", lu_count); else passed++;
    endtask

    task automatic test_no_hazard();
        clear();
        id_valid = 2'b11; id_rs0 = 3; id_rt0 = 4;
        ex_wr_en = 2'b11; ex_rd0 = 4; ex_rd1 = 6;
        mem_wr_en = 2'b11; mem_rd0 = 8; mem_rd1 = 10;
        #1;
        total++;
        if (load_use_stall !== 1'b0) $display("FAIL nohaz_stall: got %b want 0", load_use_stall); else passed++;
        total++;
        if (fwd_sel !== 8'h00) $display("FAIL nohaz_comb_path: got %h want 00", fwd_sel); else passed++;
        step();
        total++;
        if (fwd_sel !== 8'h04) $display("FAIL nohaz_fwd_sel: got %h want 04", fwd_sel); else passed++;
    endtask

    task automatic test_ex_priority();
        clear();
        id_valid = 2'b11; id_rt1 = 5; ex_wr_en = 2'b11; ex_rd0 = 5; ex_rd1 = 5;
        step();
        total++;
        if (fwd_sel !== 8'h80) $display("FAIL ex_prio_slot1: got %h want 80", fwd_sel); else passed++;
        ex_wr_en = 2'b01;
        step();
        total++;
        if (fwd_sel !== 8'h40) $display("FAIL ex_prio_slot0: got %h want 40", fwd_sel); else passed++;
        id_valid = 2'b01;
        step();
        total++;
        if (fwd_sel !== 8'h00) $display("FAIL ex_invalid_slot: got %h want 00", fwd_sel); else passed++;
        clear();
        id_valid = 2'b11; ex_wr_en = 2'b11; mem_wr_en = 2'b11;
        step();
        total++;
        if (fwd_sel !== 8'h00) $display("FAIL ex_reg0: got %h want 00", fwd_sel); else passed++;
    endtask

    task automatic test_mem_forward();
        clear();
        id_valid = 2'b11; id_rs1 = 7; mem_wr_en = 2'b10; mem_rd1 = 7;
        step();
        total++;
        if (fwd_sel !== 8'h30) $display("FAIL mem1_fwd_sel: got %h want 30", fwd_sel); else passed++;
        total++;
        if (mwb_slot !== 4'h4) $display("FAIL mem1_mwb_slot: got %h want 4", mwb_slot); else passed++;
        mem_wr_en = 2'b11; mem_rd0 = 7;
        step();
        total++;
        if (mwb_slot !== 4'h4) $display("FAIL mem_both_mwb_slot: got %h want 4", mwb_slot); else passed++;
        mem_wr_en = 2'b01;
        step();
        total++;
        if (fwd_sel !== 8'h30 || mwb_slot !== 4'h0) $display("FAIL mem0_fwd: got %h/%h want 30/0", fwd_sel, mwb_slot); else passed++;
        ex_wr_en = 2'b01; ex_rd0 = 7; mem_wr_en = 2'b10;
        step();
        total++;
        if (fwd_sel !== 8'h10 || mwb_slot !== 4'h0) $display("FAIL ex_over_mem: got %h/%h want 10/0", fwd_sel, mwb_slot); else passed++;
    endtask

    task automatic test_load_use();
        clear();
        id_valid = 2'b01; id_rs0 = 9; ex_wr_en = 2'b01; ex_is_load = 2'b01; ex_rd0 = 9;
        #1;
        total++;
        if (load_use_stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", load_use_stall); else passed++;
        step();
        total++;
        if (fwd_sel !== 8'h00) $display("FAIL lu_bubble: got %h want 00", fwd_sel); else passed++;
        total++;
        if (lu_count !== 16'd1) $display("FAIL lu_count1: got %h want 0001", lu_count); else passed++;
        ex_wr_en = 0; ex_is_load = 0; ex_rd0 = 0; mem_wr_en = 2'b01; mem_rd0 = 9;
        #1;
        total++;
        if (load_use_stall !== 1'b0) $display("FAIL lu_release: got %b want 0", load_use_stall); else passed++;
        step();
        total++;
        if (fwd_sel !== 8'h03 || mwb_slot !== 4'h0) $display("FAIL lu_mem_fwd: got %h/%h want 03/0", fwd_sel, mwb_slot); else passed++;
        total++;
        if (lu_count !== 16'd1) $display("FAIL lu_count_hold: got %h want 0001", lu_count); else passed++;
        clear();
        id_valid = 2'b11; ex_wr_en = 2'b11; ex_is_load = 2'b11;
        #1;
        total++;
        if (load_use_stall !== 1'b0) $display("FAIL lu_reg0: got %b want 0", load_use_stall); else passed++;
        ex_rd1 = 12; id_rt1 = 12;
        #1;
        total++;
        if (load_use_stall !== 1'b1) $display("FAIL lu_slot1: got %b want 1", load_use_stall); else passed++;
        ext_stall = 1;
        step();
        total++;
        if (lu_count !== 16'd1) $display("FAIL lu_ext_stall_count: got %h want 0001", lu_count); else passed++;
    endtask

    task automatic test_stall_flush();
        clear();
        id_valid = 2'b11; id_rt1 = 5; ex_wr_en = 2'b10; ex_rd1 = 5;
        step();
        ext_stall = 1;
        id_rt1 = 0; id_rs0 = 9; ex_wr_en = 2'b01; ex_is_load = 2'b01; ex_rd0 = 9;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (fwd_sel !== 8'h80 || lu_count !== 16'd1) $display("FAIL hold_cycle%0d: got %h/%h want 80/0001", k, fwd_sel, lu_count); else passed++;
        end
        flush = 1;
        step();
        total++;
        if (fwd_sel !== 8'h00 || lu_count !== 16'd1) $display("FAIL flush_stall: got %h/%h want 00/0001", fwd_sel, lu_count); else passed++;
        ext_stall = 0;
        step();
        total++;
        if (lu_count !== 16'd1) $display("FAIL flush_no_count: got %h want 0001", lu_count); else passed++;
    endtask

    task automatic test_saturation();
        clear();
        id_valid = 2'b01; id_rs0 = 9; ex_wr_en = 2'b01; ex_is_load = 2'b01; ex_rd0 = 9;
        for (int k = 0; k < 65536; k++) @(posedge clk);
        #1;
        total++;
        if (lu_count !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", lu_count); else passed++;
        repeat (5) step();
        total++;
        if (lu_count !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", lu_count); else passed++;
        clear();
        id_valid = 2'b11; id_rs1 = 7; mem_wr_en = 2'b10; mem_rd1 = 7;
        step();
        rst = 1;
        step();
        rst = 0;
        total++;
        if (fwd_sel !== 8'h00 || mwb_slot !== 4'h0 || lu_count !== 16'h0)
            $display("FAIL sat_reset: got %h/%h/%h want 00/0/0000", fwd_sel, mwb_slot, lu_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_ex_priority();
        test_mem_forward();
        test_load_use();
        test_stall_flush();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
